// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline registers.
// The control bundle travels ID/EX -> EX/MEM -> MEM/WB unchanged in layout.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/execution_branch_adder.sv
// Branch target adder: PC+4 plus the pre-shifted branch offset.
// Unsigned, modulo 2^DATA_W; the carry out is deliberately dropped.
module execution_branch_adder #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] offset_i,
  output logic [DATA_W-1:0] target_o
);

  assign target_o = pc_plus4_i + offset_i;

endmodule

// File: rtl/execution_mem_pipeline_reg.sv
// EX/MEM pipeline register: forms the branch target and decision, registers the
// datapath and control into MEM with stall/flush, and counts taken branches.
module execution_mem_pipeline_reg #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_pc_plus4,
  input  logic [DATA_W-1:0] ex_shift_out,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_alu_zero,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [REG_W-1:0]  ex_write_reg,
  input  logic              ex_branch,
  input  logic              ex_branch_ne,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_branch_target,
  output logic              mem_pc_src,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [REG_W-1:0]  mem_write_reg,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_reg_write,
  output logic              mem_mem_to_reg,
  output logic [CNT_W-1:0]  taken_count
);

  import mips_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] target_s;
  logic              taken_s;
  ctrl_t             ex_ctrl_s;

  logic              valid_d,  valid_q;
  logic [DATA_W-1:0] target_d, target_q;
  logic              pc_src_d, pc_src_q;
  logic [DATA_W-1:0] alu_d,    alu_q;
  logic [DATA_W-1:0] wdata_d,  wdata_q;
  logic [REG_W-1:0]  wreg_d,   wreg_q;
  ctrl_t             ctrl_d,   ctrl_q;
  logic [CNT_W-1:0]  cnt_d,    cnt_q;

  execution_branch_adder #(.DATA_W(DATA_W)) u_branch_adder (
    .pc_plus4_i (ex_pc_plus4),
    .offset_i   (ex_shift_out),
    .target_o   (target_s)
  );

  // beq takes on zero, bne on non-zero; an empty slot never takes.
  assign taken_s   = ex_valid & ex_branch & (ex_alu_zero ^ ex_branch_ne);
  assign ex_ctrl_s = '{mem_read:   ex_mem_read,
                       mem_write:  ex_mem_write,
                       reg_write:  ex_reg_write,
                       mem_to_reg: ex_mem_to_reg};

  // Next-state selection: flush beats stall, stall beats capture.
  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    pc_src_d = pc_src_q;
    alu_d    = alu_q;
    wdata_d  = wdata_q;
    wreg_d   = wreg_q;
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d  = 1'b0;
      target_d = '0;
      pc_src_d = 1'b0;
      alu_d    = '0;
      wdata_d  = '0;
      wreg_d   = '0;
      ctrl_d   = CTRL_NOP;
    end else if (!stall) begin
      valid_d  = ex_valid;
      target_d = target_s;
      pc_src_d = taken_s;
      alu_d    = ex_alu_result;
      wdata_d  = ex_write_data;
      wreg_d   = ex_write_reg;
      ctrl_d   = ex_valid ? ex_ctrl_s : CTRL_NOP;
      if (taken_s && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      valid_d  = valid_q;
      cnt_d    = cnt_q;
    end
  end

  // MEM-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      target_q <= '0;
      pc_src_q <= 1'b0;
      alu_q    <= '0;
      wdata_q  <= '0;
      wreg_q   <= '0;
      ctrl_q   <= CTRL_NOP;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
      pc_src_q <= pc_src_d;
      alu_q    <= alu_d;
      wdata_q  <= wdata_d;
      wreg_q   <= wreg_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_valid         = valid_q;
  assign mem_branch_target = target_q;
  assign mem_pc_src        = pc_src_q;
  assign mem_alu_result    = alu_q;
  assign mem_write_data    = wdata_q;
  assign mem_write_reg     = wreg_q;
  assign mem_mem_read      = ctrl_q.mem_read;
  assign mem_mem_write     = ctrl_q.mem_write;
  assign mem_reg_write     = ctrl_q.reg_write;
  assign mem_mem_to_reg    = ctrl_q.mem_to_reg;
  assign taken_count       = cnt_q;

endmodule

// File: tb/tb_execution_mem_pipeline_reg.sv
// Bench for the EX/MEM register: a wide-counter and a 2-bit-counter instance share
// stimulus and are compared every cycle against a behavioural model.
module tb_execution_mem_pipeline_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, ex_valid, ex_alu_zero, ex_branch, ex_branch_ne;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [31:0] ex_pc_plus4, ex_shift_out, ex_alu_result, ex_write_data;
  logic [4:0]  ex_write_reg;

  logic        a_valid, a_pc_src, a_mr, a_mw, a_rw, a_m2r;
  logic [31:0] a_target, a_alu, a_wdata;
  logic [4:0]  a_wreg;
  logic [15:0] a_cnt;
  logic        b_valid, b_pc_src, b_mr, b_mw, b_rw, b_m2r;
  logic [31:0] b_target, b_alu, b_wdata;
  logic [4:0]  b_wreg;
  logic [1:0]  b_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  execution_mem_pipeline_reg dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_pc_plus4(ex_pc_plus4), .ex_shift_out(ex_shift_out), .ex_alu_result(ex_alu_result),
    .ex_alu_zero(ex_alu_zero), .ex_write_data(ex_write_data), .ex_write_reg(ex_write_reg),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_valid(a_valid), .mem_branch_target(a_target), .mem_pc_src(a_pc_src),
    .mem_alu_result(a_alu), .mem_write_data(a_wdata), .mem_write_reg(a_wreg),
    .mem_mem_read(a_mr), .mem_mem_write(a_mw), .mem_reg_write(a_rw),
    .mem_mem_to_reg(a_m2r), .taken_count(a_cnt));

  execution_mem_pipeline_reg #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_pc_plus4(ex_pc_plus4), .ex_shift_out(ex_shift_out), .ex_alu_result(ex_alu_result),
    .ex_alu_zero(ex_alu_zero), .ex_write_data(ex_write_data), .ex_write_reg(ex_write_reg),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_valid(b_valid), .mem_branch_target(b_target), .mem_pc_src(b_pc_src),
    .mem_alu_result(b_alu), .mem_write_data(b_wdata), .mem_write_reg(b_wreg),
    .mem_mem_read(b_mr), .mem_mem_write(b_mw), .mem_reg_write(b_rw),
    .mem_mem_to_reg(b_m2r), .taken_count(b_cnt));

  // Behavioural model: what the MEM stage must hold, straight from the rules.
  logic        m_valid, m_pc_src, m_mr, m_mw, m_rw, m_m2r;
  logic [31:0] m_target, m_alu, m_wdata;
  logic [4:0]  m_wreg;
  int          m_taken;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_pc_src <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0; m_rw <= 1'b0; m_m2r <= 1'b0;
      m_target <= 32'd0; m_alu <= 32'd0; m_wdata <= 32'd0; m_wreg <= 5'd0; m_taken <= 0;
    end else if (flush) begin
      m_valid <= 1'b0; m_pc_src <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0; m_rw <= 1'b0; m_m2r <= 1'b0;
      m_target <= 32'd0; m_alu <= 32'd0; m_wdata <= 32'd0; m_wreg <= 5'd0;
    end else if (!stall) begin
      longint unsigned sum;
      bit take;
      sum  = longint'(ex_pc_plus4) + longint'(ex_shift_out);
      take = ex_valid && ex_branch && (ex_branch_ne ? !ex_alu_zero : ex_alu_zero);
      m_valid  <= ex_valid;
      m_target <= 32'(sum % 64'h1_0000_0000);
      m_pc_src <= take;
      m_alu    <= ex_alu_result;
      m_wdata  <= ex_write_data;
      m_wreg   <= ex_write_reg;
      m_mr     <= ex_valid && ex_mem_read;
      m_mw     <= ex_valid && ex_mem_write;
      m_rw     <= ex_valid && ex_reg_write;
      m_m2r    <= ex_valid && ex_mem_to_reg;
      if (take) m_taken <= m_taken + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid",  {a_valid, b_valid},   {m_valid, m_valid});
      check("target", {a_target, b_target}, {m_target, m_target});
      check("pc_src", {a_pc_src, b_pc_src}, {m_pc_src, m_pc_src});
      check("alu",    {a_alu, b_alu},       {m_alu, m_alu});
      check("wdata",  {a_wdata, b_wdata},   {m_wdata, m_wdata});
      check("wreg",   {a_wreg, b_wreg},     {m_wreg, m_wreg});
      check("ctrl",   {a_mr, a_mw, a_rw, a_m2r, b_mr, b_mw, b_rw, b_m2r},
                      {m_mr, m_mw, m_rw, m_m2r, m_mr, m_mw, m_rw, m_m2r});
      check("cnt16",  a_cnt, (m_taken > 65535) ? 16'hFFFF : 16'(m_taken));
      check("cnt2",   b_cnt, (m_taken > 3) ? 2'd3 : 2'(m_taken));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ex(input bit v, input logic [31:0] pc, input logic [31:0] off,
                        input bit br, input bit ne, input bit z);
    ex_valid = v; ex_pc_plus4 = pc; ex_shift_out = off;
    ex_branch = br; ex_branch_ne = ne; ex_alu_zero = z;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, {a_valid, a_target, a_pc_src, a_alu, a_wdata, a_wreg, a_mr, a_mw, a_rw, a_m2r, a_cnt}, 64'd0);
    check({tag, "_a2"}, {a_target, a_alu}, 64'd0);
    check({tag, "_b"}, {b_valid, b_pc_src, b_wreg, b_mr, b_mw, b_rw, b_m2r, b_cnt, b_wdata}, 64'd0);
    check({tag, "_b2"}, {b_target, b_alu}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    ex_alu_result = 32'd0; ex_write_data = 32'd0; ex_write_reg = 5'd0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    chk_en = 1'b1;
    rst_n = 1'b1;

    // Taken beq: 0x100 + 0x20.
    set_ex(1'b1, 32'h0000_0100, 32'h0000_0020, 1'b1, 1'b0, 1'b1);
    ex_reg_write = 1'b0;
    tick();
    check("beq_target", a_target, 32'h0000_0120);
    check("beq_pc_src", a_pc_src, 1'b1);
    check("beq_cnt", a_cnt, 16'd1);

    // Target wraps around the top of the address space.
    set_ex(1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 1'b1, 1'b1, 1'b0);
    tick();
    check("wrap_target", a_target, 32'h0000_0004);
    check("wrap_pc_src", a_pc_src, 1'b1);
    ex_alu_zero = 1'b1;
    tick();
    check("bne_not_taken", a_pc_src, 1'b0);
    check("bne_cnt", a_cnt, 16'd2);

    // Stall holds everything even while EX shows a taken branch.
    set_ex(1'b1, 32'h40, 32'h4, 1'b0, 1'b0, 1'b0);
    ex_alu_result = 32'h0000_1234; ex_reg_write = 1'b1;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b1);
      ex_alu_result = $urandom;
      tick();
      check("stall_alu", a_alu, 32'h0000_1234);
      check("stall_cnt", a_cnt, 16'd2);
    end

    // Flush beats a simultaneous stall.
    flush = 1'b1;
    tick();
    check("flush_ctl", {a_valid, a_pc_src, a_rw}, 3'b000);
    check("flush_data", {a_target, a_alu}, 64'd0);
    check("flush_cnt", a_cnt, 16'd2);
    flush = 1'b0; stall = 1'b0;

    // Empty slot: controls dropped, data still captured.
    set_ex(1'b0, 32'h10, 32'h10, 1'b1, 1'b0, 1'b1);
    ex_reg_write = 1'b1; ex_alu_result = 32'h0000_00AB;
    tick();
    check("inv_ctl", {a_valid, a_pc_src, a_rw}, 3'b000);
    check("inv_alu", a_alu, 32'h0000_00AB);
    check("inv_cnt", a_cnt, 16'd2);

    // Saturation of the 2-bit counter after a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_ex(1'b1, 32'h200, 32'h8, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("sat_cnt2", b_cnt, (i > 3) ? 2'd3 : 2'(i));
      check("sat_cnt16", a_cnt, 16'(i));
    end

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      set_ex(($urandom % 4) != 0, ($urandom % 8 == 0) ? 32'hFFFF_FFF0 : $urandom,
             $urandom, ($urandom % 2) == 1, ($urandom % 2) == 1, ($urandom % 2) == 1);
      ex_alu_result = $urandom; ex_write_data = $urandom; ex_write_reg = 5'($urandom);
      ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
      ex_reg_write = 1'($urandom); ex_mem_to_reg = 1'($urandom);
      stall = ($urandom % 5) == 0;
      flush = ($urandom % 8) == 0;
      tick();
    end
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset lands mid-cycle.
    set_ex(1'b1, 32'h300, 32'h10, 1'b1, 1'b0, 1'b1);
    tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/execution_mem_pipeline_reg.md
Name: execution_mem_pipeline_reg

Overview:
EX/MEM pipeline register for the 5-stage MIPS pipeline. It consumes the EX-stage shift-left-by-2 branch offset and adds it to PC+4 to form the branch target. It evaluates the beq/bne condition and registers the target, ALU result, store data, destination register and MEM/WB control bits into the MEM stage. It supports stall (hold) and flush (bubble), and keeps a saturating count of taken branches for performance inspection.

Parameters:
DATA_W, 32, datapath/address width
REG_W, 5, register-file index width
CNT_W, 16, taken-branch counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all MEM-stage state this cycle
flush  in  1  insert bubble into MEM stage this cycle
ex_valid  in  1  EX stage holds a real instruction
ex_pc_plus4  in  DATA_W  PC+4 of EX instruction
ex_shift_out  in  DATA_W  sign-extended immediate shifted left 2
ex_alu_result  in  DATA_W  ALU output
ex_alu_zero  in  1  ALU zero flag
ex_write_data  in  DATA_W  rt value for sw
ex_write_reg  in  REG_W  destination register index
ex_branch  in  1  instruction is beq/bne
ex_branch_ne  in  1  1 = bne, 0 = beq (ignored unless ex_branch)
ex_mem_read  in  1  lw
ex_mem_write  in  1  sw
ex_reg_write  in  1  writes register file
ex_mem_to_reg  in  1  WB selects memory data
mem_valid  out  1  MEM stage holds a real instruction
mem_branch_target  out  DATA_W  registered PC+4 + offset
mem_pc_src  out  1  registered branch-taken
mem_alu_result  out  DATA_W  registered ALU result
mem_write_data  out  DATA_W  registered store data
mem_write_reg  out  REG_W  registered destination
mem_mem_read  out  1  registered control
mem_mem_write  out  1  registered control
mem_reg_write  out  1  registered control
mem_mem_to_reg  out  1  registered control
taken_count  out  CNT_W  saturating count of captured taken branches

Behaviour:
- Reset (rst_n low, asynchronous): every output goes to 0 immediately and is held at 0 while rst_n is low. Operation resumes on the first rising edge after release.
- Target: ex_pc_plus4 + ex_shift_out, unsigned, modulo 2^DATA_W. The carry is discarded and there is no overflow flag.
- Taken condition: ex_valid & ex_branch & (ex_alu_zero XOR ex_branch_ne).
- Latency: 1 cycle. EX values captured at edge N appear on the mem_* outputs after edge N.
- Per rising edge, in priority order:
  1. flush=1: bubble. mem_valid, mem_pc_src, mem_mem_read, mem_mem_write, mem_reg_write and mem_mem_to_reg go to 0. Data fields (target, alu_result, write_data, write_reg) go to 0. taken_count is unchanged. Flush wins over a simultaneous stall.
  2. stall=1: all outputs, including taken_count, hold their values.
  3. otherwise: capture. mem_valid <= ex_valid, data fields <= EX values, mem_pc_src <= taken condition.
- Invalid capture: when ex_valid=0, all control outputs (including mem_pc_src) are forced to 0. Data fields are still captured.
- taken_count: increments by 1 only on a capture edge where the taken condition is 1. It saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset.
- No combinational path from any input to any output.

Decomposition:
- Shared package mips_pkg: DATA_W and REG_W constants, plus a control bundle typedef (mem_read, mem_write, reg_write, mem_to_reg). The same bundle is reused by the ID/EX and MEM/WB registers.
- One sub-module, execution_branch_adder: combinational 32-bit adder (pc_plus4, offset) -> target. It is instantiated here and unit-tested on its own.

Test Plan:
- Reset, then capture ex_valid=1, ex_branch=1, ex_branch_ne=0, ex_alu_zero=1, pc_plus4=0x00000100, shift_out=0x00000020 -> next cycle: mem_branch_target=0x00000120, mem_pc_src=1, taken_count=1.
- Wrap case: pc_plus4=0xFFFFFFFC, shift_out=0x00000008, bne with alu_zero=0 -> target=0x00000004, mem_pc_src=1. Same inputs with alu_zero=1 -> mem_pc_src=0.
- Stall: capture alu_result=0x1234, then stall=1 for 3 cycles while EX inputs change -> outputs stay 0x1234 and taken_count is unchanged.
- Flush priority: stall=1 and flush=1 together with a taken branch on EX -> mem_valid=0, mem_pc_src=0, mem_reg_write=0, data fields=0, taken_count unchanged.
- Invalid slot: ex_valid=0 with ex_branch=1, ex_alu_zero=1, ex_reg_write=1 -> mem_pc_src=0, mem_reg_write=0, mem_valid=0, no count increment.
- Reset and saturation: with CNT_W=2, capture 5 taken branches -> taken_count reads 1,2,3,3,3. Drop rst_n mid-cycle -> all outputs 0 before the next edge.
